// File: rtl/video_timing_gen_if.sv
// Video timing output bundle: syncs, active/read-ahead qualifiers, pixel coordinates and strobes.
interface video_timing_gen_if #(
   parameter int unsigned X_BITS = 11,
   parameter int unsigned Y_BITS = 10
);
   logic              vsync;
   logic              hsync;
   logic              data_en;
   logic              read_en;
   logic [X_BITS-1:0] x;
   logic [Y_BITS-1:0] y;
   logic              frame_start;
   logic              line_start;

   modport master (
      output vsync, hsync, data_en, read_en, x, y, frame_start, line_start
   );

   modport slave (
      input  vsync, hsync, data_en, read_en, x, y, frame_start, line_start
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator with registered sync/active decodes and a read-ahead lead.
// Define VTG_FRAME_LOCK_EN to add ext_vs, which restarts the frame on a camera vsync rising edge.
module video_timing_gen #(
   parameter int unsigned H_ACT   = 1280,
   parameter int unsigned H_FP    = 110,
   parameter int unsigned H_SYNC  = 40,
   parameter int unsigned H_BP    = 220,
   parameter int unsigned V_ACT   = 720,
   parameter int unsigned V_FP    = 5,
   parameter int unsigned V_SYNC  = 5,
   parameter int unsigned V_BP    = 20,
   parameter bit          HS_POL  = 1'b1,
   parameter bit          VS_POL  = 1'b1,
   parameter int unsigned RD_LEAD = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
`ifdef VTG_FRAME_LOCK_EN
   input  logic ext_vs,
`endif
   video_timing_gen_if.master vid
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int unsigned X_BITS  = $clog2(H_TOTAL);
   localparam int unsigned Y_BITS  = $clog2(V_TOTAL);
   localparam int unsigned H_ACT_S = H_SYNC + H_BP;
   localparam int unsigned H_ACT_E = H_ACT_S + H_ACT;
   localparam int unsigned H_RD_S  = H_ACT_S - RD_LEAD;
   localparam int unsigned H_RD_E  = H_ACT_E - RD_LEAD;
   localparam int unsigned V_ACT_S = V_SYNC + V_BP;
   localparam int unsigned V_ACT_E = V_ACT_S + V_ACT;

   if (RD_LEAD > H_SYNC + H_BP || H_ACT == 0 || V_ACT == 0) begin : g_bad_params
      $error("video_timing_gen: illegal parameter set");
   end

   logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
   logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              data_en_q, data_en_d;
   logic              read_en_q, read_en_d;
   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;
   logic              frame_start_q, frame_start_d;
   logic              line_start_q, line_start_d;

   logic h_wrap_c, v_wrap_c, h_sync_c, v_sync_c, h_act_c, v_act_c, h_rd_c;
   logic ext_rise_c;

   assign h_wrap_c = (h_cnt_q == X_BITS'(H_TOTAL - 1));
   assign v_wrap_c = (v_cnt_q == Y_BITS'(V_TOTAL - 1));
   assign h_sync_c = (32'(h_cnt_q) < H_SYNC);
   assign v_sync_c = (32'(v_cnt_q) < V_SYNC);
   assign h_act_c  = (32'(h_cnt_q) >= H_ACT_S) && (32'(h_cnt_q) < H_ACT_E);
   assign h_rd_c   = (32'(h_cnt_q) >= H_RD_S)  && (32'(h_cnt_q) < H_RD_E);
   assign v_act_c  = (32'(v_cnt_q) >= V_ACT_S) && (32'(v_cnt_q) < V_ACT_E);

`ifdef VTG_FRAME_LOCK_EN
   // Two-flop synchroniser for the asynchronous camera vsync, plus a delayed copy for edge detect.
   logic ext_meta_q, ext_sync_q, ext_prev_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ext_meta_q <= 1'b0;
         ext_sync_q <= 1'b0;
         ext_prev_q <= 1'b0;
      end else begin
         ext_meta_q <= ext_vs;
         ext_sync_q <= ext_meta_q;
         ext_prev_q <= ext_sync_q;
      end
   end

   assign ext_rise_c = ext_sync_q & ~ext_prev_q;
`else
   assign ext_rise_c = 1'b0;
`endif

   // Counter advance and output decode; while en is low syncs and coordinates hold, strobes drop.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      x_d           = x_q;
      y_d           = y_q;
      data_en_d     = 1'b0;
      read_en_d     = 1'b0;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;
      if (en) begin
         h_cnt_d = h_wrap_c ? '0 : h_cnt_q + X_BITS'(1);
         if (h_wrap_c) begin
            v_cnt_d = v_wrap_c ? '0 : v_cnt_q + Y_BITS'(1);
         end
         hsync_d       = h_sync_c ? HS_POL : ~HS_POL;
         vsync_d       = v_sync_c ? VS_POL : ~VS_POL;
         data_en_d     = h_act_c & v_act_c;
         read_en_d     = h_rd_c & v_act_c;
         x_d           = data_en_d ? X_BITS'(32'(h_cnt_q) - H_ACT_S) : '0;
         y_d           = data_en_d ? Y_BITS'(32'(v_cnt_q) - V_ACT_S) : '0;
         line_start_d  = (h_cnt_q == '0);
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      end
      // Frame lock wins over both hold and natural advance.
      if (ext_rise_c) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         data_en_q     <= 1'b0;
         read_en_q     <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         data_en_q     <= data_en_d;
         read_en_q     <= read_en_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.data_en     = data_en_q;
   assign vid.read_en     = read_en_q;
   assign vid.x           = x_q;
   assign vid.y           = y_q;
   assign vid.frame_start = frame_start_q;
   assign vid.line_start  = line_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 15x7 timing (8x4 active); a second instance covers
// RD_LEAD=0 with active-low syncs. Frame-lock scenarios run when VTG_FRAME_LOCK_EN is defined.
module tb_video_timing_gen;

   localparam int unsigned XB = 4;
   localparam int unsigned YB = 3;

   logic clk = 1'b0;
   logic rstn;
   logic en;
`ifdef VTG_FRAME_LOCK_EN
   logic ext_vs;
`endif

   always #5 clk = ~clk;

   video_timing_gen_if #(.X_BITS(XB), .Y_BITS(YB)) vif  ();
   video_timing_gen_if #(.X_BITS(XB), .Y_BITS(YB)) vif2 ();

   video_timing_gen #(
      .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
      .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .RD_LEAD(1)
   ) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
`ifdef VTG_FRAME_LOCK_EN
      .ext_vs(ext_vs),
`endif
      .vid   (vif.master)
   );

   video_timing_gen #(
      .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
      .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LEAD(0)
   ) u_dut2 (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
`ifdef VTG_FRAME_LOCK_EN
      .ext_vs(1'b0),
`endif
      .vid   (vif2.master)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   logic de_a [0:211];
   logic re_a [0:211];
   logic hs_a [0:211];

   initial begin
      int fs_n, fs_p0, fs_p1, ls_n, hs_n, vs_n, de_n, re_n, first_de;
      int ex, ey, seq_err, idle_err, lead_err, lead0_err, hs2_low, vs2_low;
      int gap_err, t_fs1, t_fs2, fs_cnt, fs_at;
      bit found;

      rstn = 1'b0;
      en   = 1'b1;
`ifdef VTG_FRAME_LOCK_EN
      ext_vs = 1'b0;
`endif
      repeat (3) tick();

      // Reset values, including idle-high syncs on the active-low instance.
      chk("rst_hsync", int'(vif.hsync), 0);
      chk("rst_vsync", int'(vif.vsync), 0);
      chk("rst_qual", int'({vif.data_en, vif.read_en, vif.frame_start, vif.line_start}), 0);
      chk("rst_xy", int'({vif.x, vif.y}), 0);
      chk("rst_pol0_syncs", int'({vif2.hsync, vif2.vsync}), 3);

      // Two full frames after reset release.
      rstn = 1'b1;
      fs_n = 0; fs_p0 = 0; fs_p1 = 0; ls_n = 0; hs_n = 0; vs_n = 0; de_n = 0; re_n = 0;
      first_de = 0; ex = 0; ey = 0; seq_err = 0; idle_err = 0; lead0_err = 0;
      hs2_low = 0; vs2_low = 0;
      for (int k = 1; k <= 210; k++) begin
         tick();
         de_a[k] = vif.data_en;
         re_a[k] = vif.read_en;
         hs_a[k] = vif.hsync;
         if (vif.frame_start) begin
            fs_n++;
            if (fs_n == 1) fs_p0 = k;
            if (fs_n == 2) fs_p1 = k;
         end
         if (vif.line_start) ls_n++;
         if (vif.hsync) hs_n++;
         if (vif.vsync) vs_n++;
         if (vif.read_en) re_n++;
         if (vif.data_en) begin
            de_n++;
            if (first_de == 0) first_de = k;
            if (int'(vif.x) != ex || int'(vif.y) != ey) seq_err++;
            ex = (ex + 1) % 8;
            if (ex == 0) ey = (ey + 1) % 4;
         end else if (vif.x != '0 || vif.y != '0) begin
            idle_err++;
         end
         if (vif2.read_en !== vif2.data_en) lead0_err++;
         if (!vif2.hsync) hs2_low++;
         if (!vif2.vsync) vs2_low++;
      end
      lead_err = 0;
      for (int k = 1; k < 210; k++) begin
         if (re_a[k] !== de_a[k+1]) lead_err++;
      end

      chk("fs_count", fs_n, 2);
      chk("fs_first", fs_p0, 1);
      chk("fs_period", fs_p1 - fs_p0, 105);
      chk("ls_count", ls_n, 14);
      chk("hs_high", hs_n, 28);
      chk("hs_edge", int'({hs_a[2], hs_a[3]}), 2);
      chk("vs_high", vs_n, 30);
      chk("de_count", de_n, 64);
      chk("de_first", first_de, 36);
      chk("xy_seq_err", seq_err, 0);
      chk("xy_idle_err", idle_err, 0);
      chk("re_count", re_n, 64);
      chk("re_lead_err", lead_err, 0);
      chk("re_lead0_err", lead0_err, 0);
      chk("pol0_hs_low", hs2_low, 28);
      chk("pol0_vs_low", vs2_low, 30);

      // Freeze for 20 clocks at x=3, then resume from x=4.
      t_fs1 = 0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (vif.frame_start) t_fs1 = cyc;
         if (vif.data_en && vif.x == 4'd3) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_x3", int'(found), 1);
      en = 1'b0;
      gap_err = 0;
      repeat (20) begin
         tick();
         if (vif.data_en || vif.read_en || vif.frame_start || vif.line_start ||
             vif.x != 4'd3 || vif.y != 3'd0) gap_err++;
      end
      chk("gap_err", gap_err, 0);
      en = 1'b1;
      for (int i = 4; i <= 7; i++) begin
         tick();
         chk("resume_x", int'({vif.data_en, vif.x}), 16 + i);
      end
      t_fs2 = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (vif.frame_start) begin
            t_fs2 = cyc;
            break;
         end
      end
      chk("en_gap_period", t_fs2 - t_fs1, 125);

      // Asynchronous reset at y=2, x=5.
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (vif.data_en && vif.y == 3'd2 && vif.x == 4'd5) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_y2x5", int'(found), 1);
      rstn = 1'b0;
      #1;
      chk("async_rst", int'({vif.hsync, vif.vsync, vif.data_en, vif.read_en,
                             vif.frame_start, vif.line_start, vif.x, vif.y}), 0);
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      chk("rst_release_fs", int'(vif.frame_start), 1);
      t_fs1 = cyc;
      t_fs2 = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (vif.frame_start) begin
            t_fs2 = cyc;
            break;
         end
      end
      chk("post_rst_period", t_fs2 - t_fs1, 105);

`ifdef VTG_FRAME_LOCK_EN
      // Lock pulse at v_cnt=3: frame_start on the fourth clock after the edge.
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (vif.data_en && vif.y == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      chk("wait_v3", int'(found), 1);
      ext_vs = 1'b1;
      fs_cnt = 0;
      repeat (3) begin
         tick();
         if (vif.frame_start) fs_cnt++;
      end
      chk("lock_early_fs", fs_cnt, 0);
      tick();
      chk("lock_fs", int'({vif.frame_start, vif.hsync, vif.data_en}), 6);
      ext_vs = 1'b0;
      // Second pulse lands on the natural wrap: exactly one frame_start, at the natural slot.
      fs_cnt = 0;
      fs_at  = 0;
      for (int k = 1; k <= 110; k++) begin
         tick();
         if (k == 101) ext_vs = 1'b1;
         if (vif.frame_start) begin
            fs_cnt++;
            fs_at = k;
         end
      end
      ext_vs = 1'b0;
      chk("lock_wrap_count", fs_cnt, 1);
      chk("lock_wrap_pos", fs_at, 105);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
